// File: rtl/scp_vram_slot_sequencer.sv
// rtl/scp_vram_slot_sequencer.sv - VRAM time-slot sequencer, CPU control register file and DTACK handshake
// Purpose: divides each line into STALL, fixed-owner PREFETCH and RUN phases. RUN mixes dedicated
//   CPU slots with round-robin layer slots.
// Ports: i_clk/i_reset (async, active high), i_ce slot enable, i_line_start, CPU bus (i_cpu_*, o_cpu_dout,
//   o_cpu_dtack_n), layer fetchers (i_lyr_req/i_lyr_addr, o_lyr_ack/o_lyr_data), single-port VRAM
//   (o_ram_addr, i_ram_din, o_ram_dout, o_ram_we_h/l active low), o_ctrl_out flat register file.
// Option: define SCP_IDLE_SLOT_CPU_EN so a pending CPU VRAM access also takes idle RUN layer slots.
module scp_vram_slot_sequencer #(
    parameter int NUM_LAYERS     = 4,
    parameter int ADDR_W         = 15,
    parameter int CPU_INTERVAL   = 8,
    parameter int STALL_SLOTS    = 4,
    parameter int PREFETCH_WORDS = 3,
    parameter int CTRL_REGS      = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_ce,
    input  logic                         i_line_start,
    input  logic                         i_cpu_cs_n,
    input  logic                         i_cpu_rw,
    input  logic                         i_cpu_uds_n,
    input  logic                         i_cpu_lds_n,
    input  logic                         i_cpu_ctrl,
    input  logic [ADDR_W-1:0]            i_cpu_addr,
    input  logic [15:0]                  i_cpu_din,
    output logic [15:0]                  o_cpu_dout,
    output logic                         o_cpu_dtack_n,
    input  logic [NUM_LAYERS-1:0]        i_lyr_req,
    input  logic [NUM_LAYERS*ADDR_W-1:0] i_lyr_addr,
    output logic [NUM_LAYERS-1:0]        o_lyr_ack,
    output logic [15:0]                  o_lyr_data,
    output logic [ADDR_W-1:0]            o_ram_addr,
    input  logic [15:0]                  i_ram_din,
    output logic [15:0]                  o_ram_dout,
    output logic                         o_ram_we_h,
    output logic                         o_ram_we_l,
    output logic [CTRL_REGS*16-1:0]      o_ctrl_out
);
    localparam int LW       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CW       = (CTRL_REGS > 1) ? $clog2(CTRL_REGS) : 1;
    localparam int SLOT_W   = 16;
    localparam int PF_SLOTS = NUM_LAYERS * PREFETCH_WORDS;

    typedef enum logic [1:0] {PH_STALL = 2'd0, PH_PREFETCH = 2'd1, PH_RUN = 2'd2} phase_t;

    phase_t                r_phase;
    logic [SLOT_W-1:0]     r_slot;
    logic [LW-1:0]         r_last_grant;
    logic                  r_pending;
    logic                  r_p_rw;
    logic                  r_p_uds_n;
    logic                  r_p_lds_n;
    logic [ADDR_W-1:0]     r_p_addr;
    logic [15:0]           r_p_din;
    logic                  r_prev_cs_n;
    logic [15:0]           r_cpu_dout;
    logic                  r_dtack_n;
    logic [NUM_LAYERS-1:0] r_lyr_ack;
    logic [15:0]           r_lyr_data;
    logic [15:0]           r_ctrl [CTRL_REGS];

    logic [ADDR_W-1:0]     w_lyr_addr [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] w_elig;
    logic                  w_grant;
    logic [LW-1:0]         w_grant_idx;
    logic [LW-1:0]         w_rr_idx;
    logic                  w_cpu_go;
    logic                  w_cs_edge;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lyr
        assign w_lyr_addr[g] = i_lyr_addr[g*ADDR_W +: ADDR_W];
    end

    for (genvar g = 0; g < CTRL_REGS; g++) begin : g_ctrl
        assign o_ctrl_out[g*16 +: 16] = r_ctrl[g];
    end

    // A layer whose ack is showing this slot is still holding its request for the word just
    // delivered, so it is skipped in RUN arbitration.
    assign w_elig    = i_lyr_req & ~r_lyr_ack;
    assign w_cs_edge = ~i_cpu_cs_n & r_prev_cs_n;

    // Slot decode: who owns the VRAM during the current slot.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_rr_idx    = '0;
        w_cpu_go    = 1'b0;
        case (r_phase)
            PH_PREFETCH: begin
                // Prefetch slots stream consecutive words to one fixed owner.
                w_grant_idx = LW'(r_slot / SLOT_W'(PREFETCH_WORDS));
                w_grant     = i_lyr_req[w_grant_idx];
            end
            PH_RUN: begin
                if (r_slot == '0) begin
                    w_cpu_go = r_pending;
                end else begin
                    for (int k = 1; k <= NUM_LAYERS; k++) begin
                        w_rr_idx = LW'((int'(r_last_grant) + k) % NUM_LAYERS);
                        if (!w_grant && w_elig[w_rr_idx]) begin
                            w_grant     = 1'b1;
                            w_grant_idx = w_rr_idx;
                        end
                    end
`ifdef SCP_IDLE_SLOT_CPU_EN
                    if (!w_grant) begin
                        w_cpu_go = r_pending;
                    end
`else
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_ram_addr = '0;
        o_ram_dout = '0;
        o_ram_we_h = 1'b1;
        o_ram_we_l = 1'b1;
        if (w_cpu_go) begin
            o_ram_addr = r_p_addr;
            o_ram_dout = r_p_din;
            o_ram_we_h = r_p_uds_n | r_p_rw;
            o_ram_we_l = r_p_lds_n | r_p_rw;
        end else if (w_grant) begin
            o_ram_addr = w_lyr_addr[w_grant_idx];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase      <= PH_STALL;
            r_slot       <= '0;
            r_last_grant <= LW'(NUM_LAYERS - 1);
            r_pending    <= 1'b0;
            r_p_rw       <= 1'b1;
            r_p_uds_n    <= 1'b1;
            r_p_lds_n    <= 1'b1;
            r_p_addr     <= '0;
            r_p_din      <= '0;
            r_prev_cs_n  <= 1'b1;
            r_cpu_dout   <= '0;
            r_dtack_n    <= 1'b1;
            r_lyr_ack    <= '0;
            r_lyr_data   <= '0;
            for (int i = 0; i < CTRL_REGS; i++) begin
                r_ctrl[i] <= '0;
            end
        end else if (i_ce) begin
            // Phase sequencing; the slot decoded this cycle still completes on a line_start.
            if (i_line_start) begin
                r_phase <= PH_STALL;
                r_slot  <= '0;
            end else begin
                case (r_phase)
                    PH_STALL: begin
                        if (r_slot == SLOT_W'(STALL_SLOTS - 1)) begin
                            r_phase <= PH_PREFETCH;
                            r_slot  <= '0;
                        end else begin
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                    end
                    PH_PREFETCH: begin
                        if (r_slot == SLOT_W'(PF_SLOTS - 1)) begin
                            r_phase <= PH_RUN;
                            r_slot  <= '0;
                        end else begin
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                    end
                    default: begin
                        if (r_slot == SLOT_W'(CPU_INTERVAL - 1)) begin
                            r_slot <= '0;
                        end else begin
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                    end
                endcase
            end

            r_lyr_ack <= '0;
            if (w_grant) begin
                r_lyr_ack[w_grant_idx] <= 1'b1;
                r_lyr_data             <= i_ram_din;
                if (r_phase == PH_RUN) begin
                    r_last_grant <= w_grant_idx;
                end
            end

            r_prev_cs_n <= i_cpu_cs_n;

            if (w_cpu_go) begin
                r_pending <= 1'b0;
                if (r_p_rw) begin
                    r_cpu_dout <= i_ram_din;
                end
            end

            // A completion seen after CS has dropped away is not acknowledged.
            if (i_cpu_cs_n) begin
                r_dtack_n <= 1'b1;
            end else if (w_cs_edge && i_cpu_ctrl) begin
                r_dtack_n <= 1'b0;
            end else if (w_cpu_go && !w_cs_edge) begin
                r_dtack_n <= 1'b0;
            end

            // Latching at the end of the slot means an edge landing in a CPU slot waits for the next one.
            if (w_cs_edge) begin
                if (i_cpu_ctrl) begin
                    if (!i_cpu_rw) begin
                        if (!i_cpu_uds_n) begin
                            r_ctrl[i_cpu_addr[CW-1:0]][15:8] <= i_cpu_din[15:8];
                        end
                        if (!i_cpu_lds_n) begin
                            r_ctrl[i_cpu_addr[CW-1:0]][7:0] <= i_cpu_din[7:0];
                        end
                    end else begin
                        r_cpu_dout <= r_ctrl[i_cpu_addr[CW-1:0]];
                    end
                end else begin
                    r_pending <= 1'b1;
                    r_p_rw    <= i_cpu_rw;
                    r_p_uds_n <= i_cpu_uds_n;
                    r_p_lds_n <= i_cpu_lds_n;
                    r_p_addr  <= i_cpu_addr;
                    r_p_din   <= i_cpu_din;
                end
            end
        end
    end

    assign o_cpu_dout    = r_cpu_dout;
    assign o_cpu_dtack_n = r_dtack_n;
    assign o_lyr_ack     = r_lyr_ack;
    assign o_lyr_data    = r_lyr_data;

endmodule

// File: tb/tb_scp_vram_slot_sequencer.sv
// tb/tb_scp_vram_slot_sequencer.sv - self-checking bench for scp_vram_slot_sequencer
module tb_scp_vram_slot_sequencer;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_ce;
    logic        i_line_start;
    logic        i_cpu_cs_n;
    logic        i_cpu_rw;
    logic        i_cpu_uds_n;
    logic        i_cpu_lds_n;
    logic        i_cpu_ctrl;
    logic [14:0] i_cpu_addr;
    logic [15:0] i_cpu_din;
    logic [15:0] o_cpu_dout;
    logic        o_cpu_dtack_n;
    logic [3:0]  i_lyr_req;
    logic [59:0] i_lyr_addr;
    logic [3:0]  o_lyr_ack;
    logic [15:0] o_lyr_data;
    logic [14:0] o_ram_addr;
    logic [15:0] i_ram_din;
    logic [15:0] o_ram_dout;
    logic        o_ram_we_h;
    logic        o_ram_we_l;
    logic [511:0] o_ctrl_out;

    scp_vram_slot_sequencer dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_ce         (i_ce),
        .i_line_start (i_line_start),
        .i_cpu_cs_n   (i_cpu_cs_n),
        .i_cpu_rw     (i_cpu_rw),
        .i_cpu_uds_n  (i_cpu_uds_n),
        .i_cpu_lds_n  (i_cpu_lds_n),
        .i_cpu_ctrl   (i_cpu_ctrl),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_din    (i_cpu_din),
        .o_cpu_dout   (o_cpu_dout),
        .o_cpu_dtack_n(o_cpu_dtack_n),
        .i_lyr_req    (i_lyr_req),
        .i_lyr_addr   (i_lyr_addr),
        .o_lyr_ack    (o_lyr_ack),
        .o_lyr_data   (o_lyr_data),
        .o_ram_addr   (o_ram_addr),
        .i_ram_din    (i_ram_din),
        .o_ram_dout   (o_ram_dout),
        .o_ram_we_h   (o_ram_we_h),
        .o_ram_we_l   (o_ram_we_l),
        .o_ctrl_out   (o_ctrl_out)
    );

    always #5 i_clk = ~i_clk;

    // VRAM model: async read, byte-write on ce.
    logic [15:0] mem [0:32767];
    assign i_ram_din = mem[o_ram_addr];
    always @(posedge i_clk) begin
        if (i_ce && !o_ram_we_h) mem[o_ram_addr][15:8] <= o_ram_dout[15:8];
        if (i_ce && !o_ram_we_l) mem[o_ram_addr][7:0]  <= o_ram_dout[7:0];
    end

    int wr_cnt = 0;
    always @(negedge i_clk) begin
        if (!o_ram_we_h || !o_ram_we_l) wr_cnt <= wr_cnt + 1;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ls_cyc = 0;

    typedef struct {
        logic        ls;
        logic [3:0]  req;
        logic [14:0] addr;
        logic [3:0]  ack;
    } vec_t;
    vec_t tv [39];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic do_line_start();
        i_line_start = 1'b1;
        ls_cyc = cyc;
        next_cycle();
        i_line_start = 1'b0;
    endtask

    task automatic goto_rel(input int n);
        while (cyc < ls_cyc + n) next_cycle();
    endtask

    task automatic cpu_set(input logic ctrl, input logic rw, input logic uds_n, input logic lds_n,
                           input logic [14:0] a, input logic [15:0] d);
        i_cpu_ctrl  = ctrl;
        i_cpu_rw    = rw;
        i_cpu_uds_n = uds_n;
        i_cpu_lds_n = lds_n;
        i_cpu_addr  = a;
        i_cpu_din   = d;
        i_cpu_cs_n  = 1'b0;
    endtask

    task automatic wait_dtack(output int at);
        bit got;
        got = 1'b0;
        at  = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge i_clk);
            if (!o_cpu_dtack_n) begin
                got = 1'b1;
                at  = cyc;
            end else begin
                next_cycle();
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL dtack_timeout: got none expected low within 40 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int d;
        int wc0;
        tv[0]  = '{1'b1, 4'hF, 15'h0000, 4'h0};
        tv[1]  = '{1'b0, 4'hF, 15'h0000, 4'h0};
        tv[2]  = '{1'b0, 4'hF, 15'h0000, 4'h0};
        tv[3]  = '{1'b0, 4'hF, 15'h0000, 4'h0};
        tv[4]  = '{1'b0, 4'hF, 15'h0000, 4'h0};
        tv[5]  = '{1'b0, 4'hF, 15'h1000, 4'h0};
        tv[6]  = '{1'b0, 4'hF, 15'h1000, 4'h1};
        tv[7]  = '{1'b0, 4'hF, 15'h1000, 4'h1};
        tv[8]  = '{1'b0, 4'hF, 15'h2000, 4'h1};
        tv[9]  = '{1'b0, 4'hF, 15'h2000, 4'h2};
        tv[10] = '{1'b0, 4'hF, 15'h2000, 4'h2};
        tv[11] = '{1'b0, 4'hF, 15'h3000, 4'h2};
        tv[12] = '{1'b0, 4'hF, 15'h3000, 4'h4};
        tv[13] = '{1'b0, 4'hF, 15'h3000, 4'h4};
        tv[14] = '{1'b0, 4'hF, 15'h4000, 4'h4};
        tv[15] = '{1'b0, 4'hF, 15'h4000, 4'h8};
        tv[16] = '{1'b0, 4'hF, 15'h4000, 4'h8};
        tv[17] = '{1'b0, 4'hF, 15'h0000, 4'h8};
        tv[18] = '{1'b0, 4'hF, 15'h1000, 4'h0};
        tv[19] = '{1'b0, 4'hF, 15'h2000, 4'h1};
        tv[20] = '{1'b0, 4'hF, 15'h3000, 4'h2};
        tv[21] = '{1'b0, 4'hF, 15'h4000, 4'h4};
        tv[22] = '{1'b0, 4'hF, 15'h1000, 4'h8};
        tv[23] = '{1'b0, 4'hF, 15'h2000, 4'h1};
        tv[24] = '{1'b0, 4'hF, 15'h3000, 4'h2};
        tv[25] = '{1'b0, 4'hF, 15'h0000, 4'h4};
        tv[26] = '{1'b0, 4'hF, 15'h4000, 4'h0};
        tv[27] = '{1'b0, 4'hA, 15'h2000, 4'h8};
        tv[28] = '{1'b0, 4'hA, 15'h4000, 4'h2};
        tv[29] = '{1'b0, 4'hA, 15'h2000, 4'h8};
        tv[30] = '{1'b0, 4'hA, 15'h4000, 4'h2};
        tv[31] = '{1'b0, 4'hA, 15'h2000, 4'h8};
        tv[32] = '{1'b0, 4'hA, 15'h4000, 4'h2};
        tv[33] = '{1'b0, 4'hA, 15'h0000, 4'h8};
        tv[34] = '{1'b0, 4'hA, 15'h2000, 4'h0};
        tv[35] = '{1'b0, 4'hA, 15'h4000, 4'h2};
        tv[36] = '{1'b0, 4'h2, 15'h2000, 4'h8};
        tv[37] = '{1'b0, 4'h2, 15'h0000, 4'h2};
        tv[38] = '{1'b0, 4'h2, 15'h2000, 4'h0};

        for (int a = 0; a < 32768; a++) mem[a] <= 16'(a) ^ 16'hA5C3;
        i_reset = 1'b1; i_ce = 1'b1; i_line_start = 1'b0;
        i_cpu_cs_n = 1'b1; i_cpu_rw = 1'b1; i_cpu_uds_n = 1'b1; i_cpu_lds_n = 1'b1;
        i_cpu_ctrl = 1'b0; i_cpu_addr = '0; i_cpu_din = '0; i_lyr_req = '0;
        i_lyr_addr = {15'h4000, 15'h3000, 15'h2000, 15'h1000};

        // Reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_dtack", 32'(o_cpu_dtack_n), 32'h1);
        chk("rst_dout", 32'(o_cpu_dout), 32'h0);
        chk("rst_ack", 32'(o_lyr_ack), 32'h0);
        chk("rst_we", 32'({o_ram_we_h, o_ram_we_l}), 32'h3);
        chk("rst_addr", 32'(o_ram_addr), 32'h0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Line sequence with all layers requesting, then RUN arbitration patterns
        for (int v = 0; v < 39; v++) begin
            i_line_start = tv[v].ls;
            i_lyr_req    = tv[v].req;
            @(negedge i_clk);
            chk($sformatf("tbl%0d_addr", v), 32'(o_ram_addr), 32'(tv[v].addr));
            chk($sformatf("tbl%0d_ack", v), 32'(o_lyr_ack), 32'(tv[v].ack));
            if (v > 0 && tv[v].ack != 4'h0)
                chk($sformatf("tbl%0d_data", v), 32'(o_lyr_data), 32'({1'b0, tv[v-1].addr} ^ 16'hA5C3));
            next_cycle();
        end
        i_line_start = 1'b0;
        i_lyr_req    = 4'h0;

        // Control register access
        cpu_set(1'b1, 1'b0, 1'b0, 1'b0, 15'd5, 16'hBEEF);
        next_cycle();
        i_cpu_cs_n = 1'b1;
        @(negedge i_clk);
        chk("t5_dtack", 32'(o_cpu_dtack_n), 32'h0);
        chk("t5_reg5", 32'(o_ctrl_out[5*16 +: 16]), 32'hBEEF);
        next_cycle();
        @(negedge i_clk);
        chk("t5_dtack_rel", 32'(o_cpu_dtack_n), 32'h1);
        next_cycle();
        cpu_set(1'b1, 1'b1, 1'b0, 1'b0, 15'd5, 16'h0000);
        next_cycle();
        i_cpu_cs_n = 1'b1;
        @(negedge i_clk);
        chk("t5_read", 32'(o_cpu_dout), 32'hBEEF);
        chk("t5_read_dtack", 32'(o_cpu_dtack_n), 32'h0);
        next_cycle();
        cpu_set(1'b1, 1'b0, 1'b1, 1'b0, 15'd6, 16'hCAFE);
        next_cycle();
        i_cpu_cs_n = 1'b1;
        @(negedge i_clk);
        chk("t5_lds_only", 32'(o_ctrl_out[6*16 +: 16]), 32'h00FE);
        next_cycle();
        cpu_set(1'b1, 1'b0, 1'b0, 1'b1, 15'd6, 16'h1234);
        next_cycle();
        i_cpu_cs_n = 1'b1;
        @(negedge i_clk);
        chk("t5_uds_only", 32'(o_ctrl_out[6*16 +: 16]), 32'h12FE);
        next_cycle();
        i_cpu_ctrl = 1'b0;

        // VRAM write, low byte only, then read back
        do_line_start();
        goto_rel(19);
        cpu_set(1'b0, 1'b0, 1'b1, 1'b0, 15'h0100, 16'h1234);
        goto_rel(24);
        @(negedge i_clk);
        chk("t4_not_early", 32'(o_ram_we_l), 32'h1);
        goto_rel(25);
        @(negedge i_clk);
        chk("t4_we_l", 32'(o_ram_we_l), 32'h0);
        chk("t4_we_h", 32'(o_ram_we_h), 32'h1);
        chk("t4_addr", 32'(o_ram_addr), 32'h0100);
        chk("t4_dout", 32'(o_ram_dout), 32'h1234);
        goto_rel(26);
        @(negedge i_clk);
        chk("t4_dtack", 32'(o_cpu_dtack_n), 32'h0);
        goto_rel(27);
        i_cpu_cs_n = 1'b1;
        goto_rel(28);
        @(negedge i_clk);
        chk("t4_dtack_rel", 32'(o_cpu_dtack_n), 32'h1);
        goto_rel(29);
        cpu_set(1'b0, 1'b1, 1'b0, 1'b0, 15'h0100, 16'h0000);
        goto_rel(33);
        @(negedge i_clk);
        chk("t4_rd_addr", 32'(o_ram_addr), 32'h0100);
        chk("t4_rd_we", 32'({o_ram_we_h, o_ram_we_l}), 32'h3);
        goto_rel(34);
        @(negedge i_clk);
        chk("t4_rd_low", 32'(o_cpu_dout[7:0]), 32'h34);
        chk("t4_rd_word", 32'(o_cpu_dout), 32'hA434);
        chk("t4_rd_dtack", 32'(o_cpu_dtack_n), 32'h0);
        goto_rel(35);
        i_cpu_cs_n = 1'b1;

        // Edge at run counter 1, then edge coinciding with a CPU slot
        do_line_start();
        goto_rel(18);
        cpu_set(1'b0, 1'b1, 1'b0, 1'b0, 15'h0100, 16'h0000);
        wait_dtack(d);
`ifdef SCP_IDLE_SLOT_CPU_EN
        chk("t6_cnt1_slot", 32'(d - ls_cyc), 32'd20);
`else
        chk("t6_cnt1_slot", 32'(d - ls_cyc), 32'd26);
`endif
        chk("t6_data", 32'(o_cpu_dout), 32'hA434);
        next_cycle();
        i_cpu_cs_n = 1'b1;
        next_cycle();
        do_line_start();
        goto_rel(25);
        cpu_set(1'b0, 1'b1, 1'b0, 1'b0, 15'h0100, 16'h0000);
        wait_dtack(d);
`ifdef SCP_IDLE_SLOT_CPU_EN
        chk("t6_cnt0_slot", 32'(d - ls_cyc), 32'd27);
`else
        chk("t6_cnt0_slot", 32'(d - ls_cyc), 32'd34);
`endif
        next_cycle();
        i_cpu_cs_n = 1'b1;
        next_cycle();

        // Reset mid-RUN with a pending write
        do_line_start();
        goto_rel(19);
        cpu_set(1'b0, 1'b0, 1'b0, 1'b0, 15'h0200, 16'hFFFF);
        goto_rel(21);
        i_reset    = 1'b1;
        i_cpu_cs_n = 1'b1;
        @(negedge i_clk);
        chk("t1_dtack", 32'(o_cpu_dtack_n), 32'h1);
        chk("t1_dout", 32'(o_cpu_dout), 32'h0);
        chk("t1_ack", 32'(o_lyr_ack), 32'h0);
        chk("t1_lyr_data", 32'(o_lyr_data), 32'h0);
        chk("t1_we", 32'({o_ram_we_h, o_ram_we_l}), 32'h3);
        chk("t1_addr", 32'(o_ram_addr), 32'h0);
        chk("t1_ctrl_bits", 32'($countones(o_ctrl_out)), 32'h0);
        wc0 = wr_cnt;
        repeat (2) next_cycle();
        i_reset = 1'b0;
        repeat (40) next_cycle();
        @(negedge i_clk);
        chk("t1_no_write", 32'(wr_cnt), 32'(wc0));
        chk("t1_mem", 32'(mem[15'h0200]), 32'hA7C3);
        chk("t1_dtack_idle", 32'(o_cpu_dtack_n), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
